// File: rtl/wam_ctl.sv
// Whack-a-mole game controller: start/switch edge detection, gap/up/over
// sequencing, a game timer and LFSR-driven mole selection. Every output is registered.
module wam_ctl #(
  parameter int         MOLE_TICKS = 8,
  parameter int         GAP_TICKS  = 2,
  parameter int         GAME_TICKS = 60,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       start,
  input  logic [3:0] sw,
  output logic [3:0] mole,
  output logic       hit,
  output logic       miss,
  output logic [7:0] time_left,
  output logic       busy,
  output logic       over
);

  typedef enum logic [1:0] {IDLE, GAP, UP, OVER} state_t;

  localparam logic [7:0] MOLE_LD = 8'(MOLE_TICKS);
  localparam logic [7:0] GAP_LD  = 8'(GAP_TICKS);
  localparam logic [7:0] GAME_LD = 8'(GAME_TICKS);

  state_t     state_q, state_d;
  logic       start_q;
  logic [3:0] sw_q;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic [7:0] mole_cnt_q, mole_cnt_d;
  logic [7:0] time_q, time_d;
  logic [1:0] prev_idx_q, prev_idx_d;
  logic [3:0] mole_q, mole_d;
  logic       hit_q, hit_d;
  logic       miss_q, miss_d;
  logic       busy_q, busy_d;
  logic       over_q, over_d;

  logic       start_edge;
  logic [3:0] sw_edge;
  logic [1:0] idx;
  logic       in_play;
  logic       hit_ok;
  logic       timeout;
  logic       last_tick;

  assign start_edge = start & ~start_q;
  assign sw_edge    = sw & ~sw_q;
  assign in_play    = (state_q == GAP) || (state_q == UP);
  assign hit_ok     = (state_q == UP) && ((sw_edge & mole_q) != 4'b0000);
  assign timeout    = (state_q == UP) && tick && (mole_cnt_q == 8'd1);
  assign last_tick  = in_play && tick && (time_q == 8'd1);
  // Bump the LFSR pick by one when it would repeat the previous mole.
  assign idx        = (lfsr_q[1:0] == prev_idx_q) ? lfsr_q[1:0] + 2'd1 : lfsr_q[1:0];

  assign mole      = mole_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign time_left = time_q;
  assign busy      = busy_q;
  assign over      = over_q;

  // State and datapath registers; clr wins over everything and re-arms the edge detectors.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      start_q    <= start;
      sw_q       <= sw;
      lfsr_q     <= SEED;
      gap_cnt_q  <= '0;
      mole_cnt_q <= '0;
      time_q     <= '0;
      prev_idx_q <= '0;
      mole_q     <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      busy_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      sw_q       <= sw;
      lfsr_q     <= lfsr_d;
      gap_cnt_q  <= gap_cnt_d;
      mole_cnt_q <= mole_cnt_d;
      time_q     <= time_d;
      prev_idx_q <= prev_idx_d;
      mole_q     <= mole_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      busy_q     <= busy_d;
      over_q     <= over_d;
    end
  end

  // Next state, counters and LFSR; the game-timer expiry is applied last so it overrides GAP/UP moves.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    mole_cnt_d = mole_cnt_q;
    time_d     = time_q;
    prev_idx_d = prev_idx_q;
    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    case (state_q)
      IDLE, OVER: begin
        if (start_edge) begin
          state_d   = GAP;
          time_d    = GAME_LD;
          gap_cnt_d = GAP_LD;
        end
      end
      GAP: begin
        if (tick) begin
          gap_cnt_d = gap_cnt_q - 8'd1;
          if (gap_cnt_q == 8'd1) begin
            state_d    = UP;
            mole_cnt_d = MOLE_LD;
          end
        end
      end
      UP: begin
        if (hit_ok) begin
          state_d   = GAP;
          gap_cnt_d = GAP_LD;
        end else if (tick) begin
          mole_cnt_d = mole_cnt_q - 8'd1;
          if (mole_cnt_q == 8'd1) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LD;
          end
        end
      end
      default: ;
    endcase
    if (in_play && tick) begin
      time_d = time_q - 8'd1;
      if (last_tick) state_d = OVER;
    end
    // Only a mole that actually lights counts as the previous one.
    if (state_q == GAP && state_d == UP) prev_idx_d = idx;
  end

  // Registered output values derived from the upcoming state.
  always_comb begin
    mole_d = '0;
    if (state_d == UP) mole_d = (state_q == GAP) ? (4'b0001 << idx) : mole_q;
    hit_d  = hit_ok;
    miss_d = timeout && !hit_ok && !last_tick;
    busy_d = (state_d == GAP) || (state_d == UP);
    over_d = (state_d == OVER);
  end

endmodule

// File: tb/tb_wam_ctl.sv
// Bench for wam_ctl: behavioural game model checked every cycle, directed
// scenarios with literal expectations, then randomized play.
module tb_wam_ctl;

  localparam int MT = 3;
  localparam int GT = 2;
  localparam int GM = 10;

  logic       clk = 1'b0;
  logic       clr, tick, start;
  logic [3:0] sw;
  logic [3:0] mole;
  logic       hit, miss, busy, over;
  logic [7:0] time_left;

  int checks = 0;
  int errors = 0;
  int mole_count = 0;

  wam_ctl #(.MOLE_TICKS(MT), .GAP_TICKS(GT), .GAME_TICKS(GM), .SEED(8'hA5)) dut (
    .clk(clk), .clr(clr), .tick(tick), .start(start), .sw(sw),
    .mole(mole), .hit(hit), .miss(miss), .time_left(time_left),
    .busy(busy), .over(over)
  );

  always #5 clk = ~clk;

  // Behavioural model: game described as "playing or not", current mole index (-1 = none),
  // and plain tick countdowns.
  bit         m_valid = 0;
  bit         m_busy, m_over, m_hit, m_miss;
  int         m_time, m_gap, m_up, m_cur;
  logic [7:0] m_lfsr;
  logic [1:0] m_prev;
  logic       m_start_q;
  logic [3:0] m_sw_q;
  logic [3:0] b_last, b_prev_out;

  function automatic void model_step();
    bit         se, shown, last;
    logic [3:0] swe;
    int         pick;
    if (clr) begin
      m_valid = 1; m_busy = 0; m_over = 0; m_hit = 0; m_miss = 0;
      m_time = 0; m_gap = 0; m_up = 0; m_cur = -1;
      m_lfsr = 8'hA5; m_prev = 2'd0; m_start_q = start; m_sw_q = sw;
      b_last = 4'b0001; b_prev_out = 4'b0000;
      return;
    end
    se = start && !m_start_q;
    swe = sw & ~m_sw_q;
    m_hit = 0; m_miss = 0; shown = 0;
    pick = int'(m_lfsr[1:0]);
    if (pick == int'(m_prev)) pick = (pick + 1) % 4;
    if (!m_busy) begin
      if (se) begin
        m_busy = 1; m_over = 0; m_time = GM; m_gap = GT; m_cur = -1;
      end
    end else begin
      last = tick && (m_time == 1);
      if (m_cur >= 0) begin
        if (swe[m_cur]) begin
          m_hit = 1; m_cur = -1; m_gap = GT;
        end else if (tick) begin
          m_up = m_up - 1;
          if (m_up == 0) begin
            m_miss = !last; m_cur = -1; m_gap = GT;
          end
        end
      end else if (tick) begin
        m_gap = m_gap - 1;
        if (m_gap == 0) begin
          m_cur = pick; m_up = MT; shown = 1;
        end
      end
      if (tick) begin
        m_time = m_time - 1;
        if (m_time == 0) begin
          m_busy = 0; m_over = 1; m_cur = -1;
        end
      end
      if (shown && m_cur >= 0) m_prev = 2'(m_cur);
    end
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    m_start_q = start;
    m_sw_q = sw;
  endfunction

  // Per-cycle comparison against the model plus structural invariants.
  always @(posedge clk) begin
    logic [3:0] exp_mole;
    model_step();
    #1;
    if (m_valid) begin
      exp_mole = (m_cur < 0) ? 4'b0000 : 4'(1 << m_cur);
      checks++;
      if (mole !== exp_mole || hit !== m_hit || miss !== m_miss ||
          time_left !== 8'(m_time) || busy !== m_busy || over !== m_over) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got mole=%b hit=%b miss=%b tl=%0d busy=%b over=%b exp mole=%b hit=%b miss=%b tl=%0d busy=%b over=%b",
                 $time, mole, hit, miss, time_left, busy, over,
                 exp_mole, m_hit, m_miss, m_time, m_busy, m_over);
      end
      checks++;
      if ($countones(mole) > 1 || (hit && miss)) begin
        errors++;
        $display("FAIL invariant t=%0t got mole=%b hit=%b miss=%b exp onehot_or_zero and not both", $time, mole, hit, miss);
      end
      if (mole != 4'b0000 && b_prev_out == 4'b0000) begin
        mole_count++;
        checks++;
        if (mole == b_last) begin
          errors++;
          $display("FAIL repeat_mole t=%0t got mole=%b exp different from previous %b", $time, mole, b_last);
        end
        b_last = mole;
      end
      b_prev_out = mole;
    end
  end

  // Driver side.
  bit tick_en;
  int tphase;
  int last_wait;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      if (tick_en) begin
        tick = (tphase == 3);
        tphase = (tphase + 1) % 4;
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_mole(input string name);
    int n;
    n = 0;
    while (mole == 4'b0000 && n < 200) begin cyc(1); n++; end
    last_wait = n;
    chk({name, "_seen"}, int'(mole != 4'b0000), 1);
  endtask

  task automatic wait_sig(input string name, input bit want_over);
    int n;
    n = 0;
    while ((want_over ? over : miss) != 1'b1 && n < 200) begin cyc(1); n++; end
    chk({name, "_seen"}, int'(want_over ? over : miss), 1);
  endtask

  initial begin
    logic [3:0] target;
    clr = 1; tick = 0; start = 0; sw = 4'h0; tick_en = 0; tphase = 0;
    cyc(2);
    clr = 0;
    cyc(1);
    chk("reset_time_left", time_left, 0);
    chk("reset_busy", busy, 0);
    chk("reset_over", over, 0);
    chk("reset_mole", mole, 0);

    // Start, two gap ticks, first mole.
    start = 1; cyc(1); start = 0;
    chk("start_busy", busy, 1);
    chk("start_time_left", time_left, 10);
    chk("start_mole", mole, 0);
    tick_en = 1; tphase = 0;
    wait_mole("first_mole");
    chk("first_mole_delay", last_wait, 8);
    chk("first_mole_time_left", time_left, 8);
    chk("first_mole_onehot", $countones(mole), 1);
    chk("first_mole_not_idx0", int'(mole == 4'b0001), 0);

    // Matching hit: one-cycle pulse, mole cleared.
    sw = mole; cyc(1);
    chk("hit_pulse", hit, 1);
    chk("hit_mole_clear", mole, 0);
    chk("hit_busy", busy, 1);
    sw = 4'h0; cyc(1);
    chk("hit_one_cycle", hit, 0);

    // Non-matching switches then timeout.
    wait_mole("second_mole");
    sw = ~mole; cyc(1);
    chk("nonmatch_hit", hit, 0);
    chk("nonmatch_miss", miss, 0);
    chk("nonmatch_mole_kept", $countones(mole), 1);
    sw = 4'h0;
    wait_sig("miss", 1'b0);
    chk("miss_mole_clear", mole, 0);
    chk("miss_no_hit", hit, 0);
    cyc(1);
    chk("miss_one_cycle", miss, 0);

    // Run to game over.
    wait_sig("over", 1'b1);
    chk("over_time_left", time_left, 0);
    chk("over_busy", busy, 0);
    chk("over_mole", mole, 0);
    tick_en = 0; tick = 0;
    cyc(2);
    start = 1; cyc(1);
    chk("restart_time_left", time_left, 10);
    chk("restart_busy", busy, 1);
    start = 0; cyc(1);
    start = 1; cyc(1);
    chk("busy_start_time_left", time_left, 10);
    chk("busy_start_busy", busy, 1);
    start = 0;

    // Hit edge on the same cycle as the timeout tick.
    tick_en = 1; tphase = 0;
    wait_mole("race_mole");
    target = mole;
    cyc(11);
    sw = target; cyc(1);
    chk("race_hit", hit, 1);
    chk("race_miss", miss, 0);
    chk("race_mole", mole, 0);
    sw = 4'h0;

    // Inputs held through reset produce no edges.
    tick_en = 0; tick = 0;
    sw = 4'hF; start = 1; clr = 1; cyc(2);
    clr = 0; cyc(3);
    chk("held_no_start", busy, 0);
    chk("held_no_hit", hit, 0);
    start = 0; cyc(1);
    start = 1; cyc(1);
    chk("held_then_start", busy, 1);
    tick_en = 1; tphase = 0;
    wait_mole("clr_mole");
    clr = 1; cyc(1);
    chk("clr_mid_up_mole", mole, 0);
    chk("clr_mid_up_time", time_left, 0);
    chk("clr_mid_up_flags", {hit, miss, busy, over}, 0);
    clr = 0; sw = 4'h0; start = 0; tick_en = 0; tick = 0;
    cyc(1);

    // Randomized play until enough moles have been shown.
    for (int i = 0; i < 40000 && mole_count < 220; i++) begin
      int b;
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 14) == 0) start = ~start;
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom_range(0, 3);
        sw[b] = ~sw[b];
      end
      if ($urandom_range(0, 5) == 0) sw = sw | mole;
      clr = ($urandom_range(0, 699) == 0);
      cyc(1);
    end
    clr = 0; tick = 0;
    chk("moles_200", int'(mole_count >= 200), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wam_ctl.md
WAM_CTL -- requirements
Module: wam_ctl

Interface
REQ-001 The block SHALL have parameter MOLE_TICKS, default 8, meaning tick periods a mole stays up before counting as a miss.
REQ-002 The block SHALL have parameter GAP_TICKS, default 2, meaning tick periods with no mole shown between moles.
REQ-003 The block SHALL have parameter GAME_TICKS, default 60, meaning game length in tick periods (1..255).
REQ-004 The block SHALL have parameter SEED, default 8'hA5, meaning the non-zero LFSR reset value.
REQ-005 The port list SHALL be as follows (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- clr  in  1  reset; one clock; reset is synchronous and active-high.
- tick  in  1  single-cycle timebase strobe.
- start  in  1  start button, level; rising edge acts.
- sw  in  4  player hit switches; rising edges act.
- mole  out  4  one-hot active mole LED, 0 when none is active.
- hit  out  1  one-cycle pulse per scored hit; feeds the score counter.
- miss  out  1  one-cycle pulse per mole timeout.
- time_left  out  8  remaining game ticks.
- busy  out  1  high in GAP or UP.
- over  out  1  high in OVER.

Function
REQ-006 All outputs SHALL be registered.
REQ-007 The block SHALL register start and sw each cycle as start_q and sw_q, and SHALL define edges as start & ~start_q and sw & ~sw_q.
REQ-008 The states SHALL be IDLE, GAP, UP and OVER.
REQ-009 In IDLE and OVER, a start edge SHALL enter GAP, load time_left=GAME_TICKS and load gap_cnt=GAP_TICKS; other inputs SHALL be ignored.
REQ-010 In GAP, mole SHALL be 0, and each tick SHALL decrement gap_cnt.
REQ-011 In GAP, a tick with gap_cnt==1 SHALL enter UP, load mole_cnt=MOLE_TICKS and set mole=1<<idx.
REQ-012 In UP, a sw edge on the bit equal to mole SHALL assert hit for one cycle, clear mole, and enter GAP with gap_cnt=GAP_TICKS.
REQ-013 In UP, sw edges on non-mole bits SHALL be ignored, with no penalty.
REQ-014 In UP, a tick with mole_cnt==1 and no valid hit SHALL assert miss for one cycle, clear mole, and enter GAP with gap_cnt reloaded.
REQ-015 In UP, a valid hit SHALL take priority over a simultaneous timeout, so that hit=1 and miss=0.
REQ-016 Latency: a sw edge seen at cycle N SHALL produce hit=1 and mole=0 at cycle N+1.
REQ-017 While busy, each tick SHALL decrement time_left.
REQ-018 A tick with time_left==1 SHALL enter OVER with time_left=0 and mole=0; this SHALL override GAP/UP transitions.
REQ-019 A valid hit in the same cycle as the final tick SHALL still pulse hit.
REQ-020 A mole timeout in the same cycle as the final tick SHALL NOT pulse miss.
REQ-021 A start edge while busy SHALL be ignored.
REQ-022 The LFSR SHALL be 8-bit Fibonacci with taps x^8+x^6+x^5+x^4+1, shifting every non-reset cycle, so it never reaches zero.
REQ-023 Mole index selection SHALL be idx=lfsr[1:0]; if idx equals the previous mole index, idx SHALL be (idx+1) mod 4, so no consecutive repeats occur.
REQ-024 The previous mole index SHALL be 0 after reset.
REQ-025 hit and miss SHALL never both be 1, and mole SHALL be 0 or one-hot at all times.

Reset
REQ-026 A cycle with clr=1 SHALL force IDLE, mole=0, hit=0, miss=0, time_left=0, busy=0, over=0, lfsr=SEED, and clear gap_cnt, mole_cnt and the previous index.
REQ-027 During reset, start_q and sw_q SHALL load the current start and sw, so that inputs held through reset generate no edge.
REQ-028 clr SHALL override every other input, including mid-game and mid-pulse.

Verification (MOLE_TICKS=3, GAP_TICKS=2, GAME_TICKS=10, tick every 4 clk)
REQ-029 Reset then start pulse -> busy=1, time_left=10, mole=0 for 2 ticks, then mole one-hot with idx != 0.
REQ-030 Mole up; raise the matching sw bit -> next cycle hit=1 for exactly one clk, mole=0, state GAP; raise a non-matching bit instead -> no hit and no miss.
REQ-031 Mole up, no switch activity -> on the 3rd tick miss=1 for one clk, mole=0; a hit edge on the same cycle as that tick -> hit=1, miss=0.
REQ-032 Run 10 ticks -> time_left counts 10..0, over=1, busy=0, mole=0; start edge -> time_left=10, busy=1; start edge while busy -> no change.
REQ-033 Hold sw=4'hF and start=1 through clr, release clr -> no hit and no game start until start drops and rises; clr mid-UP -> all outputs 0 next cycle.
REQ-034 Run 200 moles -> no two consecutive identical idx, mole always 0 or one-hot, hit and miss never coincident.
